// File: rtl/vend_pkg.sv
// Shared types and coin constants for the candy vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        REFUND = 2'd3
    } vend_state_t;

    localparam logic [7:0] COIN_5  = 8'd5;
    localparam logic [7:0] COIN_10 = 8'd10;
    localparam logic [7:0] COIN_25 = 8'd25;
    localparam logic [7:0] COIN_50 = 8'd50;

    function automatic logic [7:0] coin_value(input logic [1:0] coin_type);
        logic [7:0] v;
        case (coin_type)
            2'b00:   v = COIN_5;
            2'b01:   v = COIN_10;
            2'b10:   v = COIN_25;
            default: v = COIN_50;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/candy_vend_ctrl_if.sv
// Coin/select/cancel strobes and display/dispense/refund outputs of the vending controller.
interface candy_vend_ctrl_if;

    logic       coin_valid;
    logic [1:0] coin_type;
    logic       select;
    logic       cancel;
    logic [7:0] sum;
    logic [2:0] candy_sum;
    logic       dispense;
    logic [7:0] change;
    logic       change_valid;
    logic       coin_reject;
    logic       busy;

    modport master (
        output coin_valid, coin_type, select, cancel,
        input  sum, candy_sum, dispense, change, change_valid, coin_reject, busy
    );

    modport slave (
        input  coin_valid, coin_type, select, cancel,
        output sum, candy_sum, dispense, change, change_valid, coin_reject, busy
    );

endinterface

// File: rtl/vend_pulse_timer.sv
// Loadable down-counter producing the dispense pulse; done marks its last cycle.
module vend_pulse_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] len,
    output logic       active,
    output logic       done
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            cnt    <= len;
            active <= (len != 4'd0);
        end else if (active) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1)
                active <= 1'b0;
        end
    end

    // Combinational so the FSM leaves VEND on the same edge that drops active.
    assign done = active && (cnt == 4'd1);

endmodule

// File: rtl/candy_vend_ctrl.sv
// Vending transaction controller: credit accumulation, vend, refund and candy count.
module candy_vend_ctrl
    import vend_pkg::*;
#(
    parameter logic [7:0] PRICE       = 8'd25,
    parameter logic [7:0] MAX_SUM     = 8'd200,
    parameter logic [3:0] VEND_CYCLES = 4'd8
) (
    input logic              clk,
    input logic              reset,
    candy_vend_ctrl_if.slave bus
);

    vend_state_t state;
    logic [7:0]  sum_q;
    logic [2:0]  candy_q;
    logic [7:0]  change_q;
    logic        change_valid_q;
    logic        coin_reject_q;
    logic        busy_q;

    logic        cancel_ok;
    logic        vend_start;
    logic        vend_done;
    logic        vend_active;
    logic [8:0]  coin_sum;

    always_comb begin
        cancel_ok  = (state == CREDIT) && bus.cancel;
        vend_start = (state == CREDIT) && !bus.cancel && bus.select && (sum_q >= PRICE);
        coin_sum   = {1'b0, sum_q} + {1'b0, coin_value(bus.coin_type)};
    end

    vend_pulse_timer u_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (vend_start),
        .len    (VEND_CYCLES),
        .active (vend_active),
        .done   (vend_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            sum_q          <= '0;
            candy_q        <= '0;
            change_q       <= '0;
            change_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            change_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            case (state)
                IDLE, CREDIT: begin
                    if (cancel_ok) begin
                        change_q       <= sum_q;
                        change_valid_q <= 1'b1;
                        sum_q          <= '0;
                        state          <= REFUND;
                        busy_q         <= 1'b1;
                        coin_reject_q  <= bus.coin_valid;
                    end else if (vend_start) begin
                        sum_q         <= sum_q - PRICE;
                        candy_q       <= (candy_q == 3'd7) ? 3'd7 : candy_q + 3'd1;
                        state         <= VEND;
                        busy_q        <= 1'b1;
                        coin_reject_q <= bus.coin_valid;
                    end else if (bus.coin_valid) begin
                        if (coin_sum <= {1'b0, MAX_SUM}) begin
                            sum_q <= coin_sum[7:0];
                            state <= CREDIT;
                        end else begin
                            coin_reject_q <= 1'b1;
                        end
                    end
                end
                VEND: begin
                    coin_reject_q <= bus.coin_valid;
                    if (vend_done) begin
                        state  <= (sum_q == 8'd0) ? IDLE : CREDIT;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    coin_reject_q <= bus.coin_valid;
                    state         <= IDLE;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sum          = sum_q;
    assign bus.candy_sum    = candy_q;
    assign bus.dispense     = vend_active;
    assign bus.change       = change_q;
    assign bus.change_valid = change_valid_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_candy_vend_ctrl.sv
// Scoreboard bench for candy_vend_ctrl: per-cycle expected outputs queued alongside stimulus.
module tb_candy_vend_ctrl;

    localparam int unsigned VC = 8;

    typedef struct packed {
        logic       cv;
        logic [1:0] ct;
        logic       sel;
        logic       can;
    } stim_t;

    typedef struct packed {
        logic [7:0] sum;
        logic [2:0] candy;
        logic       disp;
        logic [7:0] change;
        logic       chg_v;
        logic       rej;
        logic       busy;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    stim_t stim_q[$];
    obs_t  exp_q[$];

    candy_vend_ctrl_if bus ();

    candy_vend_ctrl #(
        .PRICE       (8'd25),
        .MAX_SUM     (8'd200),
        .VEND_CYCLES (4'(VC))
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic stim_t st(input logic cv, input logic [1:0] ct, input logic sel, input logic can);
        return '{cv: cv, ct: ct, sel: sel, can: can};
    endfunction

    function automatic obs_t ex(input logic [7:0] s, input logic [2:0] c, input logic d,
                                input logic [7:0] ch, input logic v, input logic r, input logic b);
        return '{sum: s, candy: c, disp: d, change: ch, chg_v: v, rej: r, busy: b};
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.sum    = bus.sum;
        o.candy  = bus.candy_sum;
        o.disp   = bus.dispense;
        o.change = bus.change;
        o.chg_v  = bus.change_valid;
        o.rej    = bus.coin_reject;
        o.busy   = bus.busy;
        return o;
    endfunction

    task automatic play(input stim_t s, output obs_t o);
        bus.coin_valid = s.cv;
        bus.coin_type  = s.ct;
        bus.select     = s.sel;
        bus.cancel     = s.can;
        @(posedge clk);
        #1;
        bus.coin_valid = 1'b0;
        bus.coin_type  = 2'b00;
        bus.select     = 1'b0;
        bus.cancel     = 1'b0;
        o = observe();
    endtask

    task automatic push(input stim_t s, input obs_t e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // Select followed by the full dispense window and the exit cycle.
    task automatic push_vend(input logic [7:0] s, input logic [2:0] c, input logic [7:0] ch);
        push(st(0, 2'b00, 1, 0), ex(s, c, 1, ch, 0, 0, 1));
        for (int unsigned i = 1; i < VC; i++)
            push(st(0, 2'b00, 0, 0), ex(s, c, 1, ch, 0, 0, 1));
        push(st(0, 2'b00, 0, 0), ex(s, c, 0, ch, 0, 0, 0));
    endtask

    task automatic test_reset();
        obs_t o, e;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(ex(0, 0, 0, 0, 0, 0, 0));
        o = observe();
        e = exp_q.pop_front();
        n_cmp++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", o, e);
        end
        reset = 1'b1;
    endtask

    task automatic test_exact_price();
        obs_t o, e;
        int k = 0;
        push(st(1, 2'b10, 0, 0), ex(25, 0, 0, 0, 0, 0, 0));
        push_vend(0, 1, 0);
        push(st(0, 2'b00, 1, 0), ex(0, 1, 0, 0, 0, 0, 0));
        while (stim_q.size() != 0) begin
            play(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL exact_price[%0d]: got %h want %h", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_accumulate();
        obs_t o, e;
        int k = 0;
        push(st(1, 2'b11, 0, 0), ex(50, 1, 0, 0, 0, 0, 0));
        push(st(1, 2'b01, 0, 0), ex(60, 1, 0, 0, 0, 0, 0));
        push(st(1, 2'b00, 0, 0), ex(65, 1, 0, 0, 0, 0, 0));
        push_vend(40, 2, 0);
        push_vend(15, 3, 0);
        push(st(0, 2'b00, 1, 0), ex(15, 3, 0, 0, 0, 0, 0));
        push(st(0, 2'b00, 0, 1), ex(0, 3, 0, 15, 1, 0, 1));
        push(st(0, 2'b00, 0, 0), ex(0, 3, 0, 15, 0, 0, 0));
        while (stim_q.size() != 0) begin
            play(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL accumulate[%0d]: got %h want %h", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_overflow();
        obs_t o, e;
        int k = 0;
        for (int unsigned i = 1; i <= 4; i++)
            push(st(1, 2'b11, 0, 0), ex(8'(50 * i), 3, 0, 15, 0, 0, 0));
        push(st(1, 2'b00, 0, 0), ex(200, 3, 0, 15, 0, 1, 0));
        push(st(0, 2'b00, 0, 0), ex(200, 3, 0, 15, 0, 0, 0));
        push(st(1, 2'b11, 0, 0), ex(200, 3, 0, 15, 0, 1, 0));
        push(st(1, 2'b01, 1, 0), ex(175, 4, 1, 15, 0, 1, 1));
        push(st(1, 2'b00, 1, 0), ex(175, 4, 1, 15, 0, 1, 1));
        for (int unsigned i = 2; i < VC; i++)
            push(st(0, 2'b00, 0, 0), ex(175, 4, 1, 15, 0, 0, 1));
        push(st(0, 2'b00, 0, 0), ex(175, 4, 0, 15, 0, 0, 0));
        push(st(0, 2'b00, 0, 1), ex(0, 4, 0, 175, 1, 0, 1));
        push(st(0, 2'b00, 0, 0), ex(0, 4, 0, 175, 0, 0, 0));
        while (stim_q.size() != 0) begin
            play(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL overflow[%0d]: got %h want %h", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_cancel();
        obs_t o, e;
        int k = 0;
        push(st(1, 2'b01, 0, 0), ex(10, 4, 0, 175, 0, 0, 0));
        push(st(1, 2'b10, 0, 0), ex(35, 4, 0, 175, 0, 0, 0));
        push(st(0, 2'b00, 0, 1), ex(0, 4, 0, 35, 1, 0, 1));
        push(st(1, 2'b00, 0, 0), ex(0, 4, 0, 35, 0, 1, 0));
        push(st(0, 2'b00, 0, 0), ex(0, 4, 0, 35, 0, 0, 0));
        push(st(0, 2'b00, 0, 1), ex(0, 4, 0, 35, 0, 0, 0));
        push(st(0, 2'b00, 0, 0), ex(0, 4, 0, 35, 0, 0, 0));
        while (stim_q.size() != 0) begin
            play(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL cancel[%0d]: got %h want %h", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_priority();
        obs_t o, e;
        int k = 0;
        push(st(1, 2'b11, 0, 0), ex(50, 4, 0, 35, 0, 0, 0));
        push(st(1, 2'b10, 1, 1), ex(0, 4, 0, 50, 1, 1, 1));
        push(st(0, 2'b00, 0, 0), ex(0, 4, 0, 50, 0, 0, 0));
        while (stim_q.size() != 0) begin
            play(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL priority[%0d]: got %h want %h", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_saturation();
        obs_t o, e;
        int k = 0;
        for (int unsigned i = 1; i <= 4; i++)
            push(st(1, 2'b11, 0, 0), ex(8'(50 * i), 4, 0, 50, 0, 0, 0));
        for (int unsigned v = 1; v <= 8; v++)
            push_vend(8'(200 - 25 * v), ((4 + v) > 7) ? 3'd7 : 3'(4 + v), 50);
        while (stim_q.size() != 0) begin
            play(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL saturation[%0d]: got %h want %h", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_reset_mid_vend();
        obs_t o, e;
        int k = 0;
        push(st(1, 2'b10, 0, 0), ex(25, 7, 0, 50, 0, 0, 0));
        push(st(1, 2'b01, 0, 0), ex(35, 7, 0, 50, 0, 0, 0));
        push(st(0, 2'b00, 1, 0), ex(10, 7, 1, 50, 0, 0, 1));
        push(st(0, 2'b00, 0, 0), ex(10, 7, 1, 50, 0, 0, 1));
        push(st(0, 2'b00, 0, 0), ex(10, 7, 1, 50, 0, 0, 1));
        while (stim_q.size() != 0) begin
            play(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_mid_vend[%0d]: got %h want %h", k, o, e);
            end
            k++;
        end
        #2 reset = 1'b0;
        #1;
        exp_q.push_back(ex(0, 0, 0, 0, 0, 0, 0));
        o = observe();
        e = exp_q.pop_front();
        n_cmp++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_async: got %h want %h", o, e);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        push(st(0, 2'b00, 0, 0), ex(0, 0, 0, 0, 0, 0, 0));
        push(st(1, 2'b00, 0, 0), ex(5, 0, 0, 0, 0, 0, 0));
        push(st(0, 2'b00, 1, 0), ex(5, 0, 0, 0, 0, 0, 0));
        k = 0;
        while (stim_q.size() != 0) begin
            play(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL after_reset[%0d]: got %h want %h", k, o, e);
            end
            k++;
        end
    endtask

    initial begin
        bus.coin_valid = 1'b0;
        bus.coin_type  = 2'b00;
        bus.select     = 1'b0;
        bus.cancel     = 1'b0;
        test_reset();
        test_exact_price();
        test_accumulate();
        test_overflow();
        test_cancel();
        test_priority();
        test_saturation();
        test_reset_mid_vend();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/candy_vend_ctrl.md
# candy_vend_ctrl

Transaction controller for the candy vending system. It accepts coin pulses, keeps the running credit, and vends a candy on request. It also tracks the number of candies dispensed and refunds the remaining credit on cancel. It sits directly upstream of `seven_seg_col_sel`, driving that block's `sum` and `candy_sum` inputs for display.

## Interface
- `PRICE`, 8'd25, candy price in cents
- `MAX_SUM`, 8'd200, credit ceiling in cents; a coin that would exceed it is rejected
- `VEND_CYCLES`, 4'd8, width of the `dispense` pulse in clocks (range 1–15)
- `clk`  in  1  system clock; all logic is on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `coin_valid`  in  1  one-cycle strobe: a coin is present on `coin_type`
- `coin_type`  in  2  coin value: 00=5, 01=10, 10=25, 11=50 cents
- `select`  in  1  one-cycle strobe requesting a candy
- `cancel`  in  1  one-cycle strobe requesting a refund
- `sum`  out  8  current credit in cents; feeds `seven_seg_col_sel.sum`
- `candy_sum`  out  3  candies dispensed since reset, saturating; feeds `seven_seg_col_sel.candy_sum`
- `dispense`  out  1  held high for `VEND_CYCLES` clocks per vend
- `change`  out  8  refund amount; valid only while `change_valid` is high
- `change_valid`  out  1  one-cycle refund strobe
- `coin_reject`  out  1  one-cycle strobe: the coin strobed in the previous cycle was not accepted
- `busy`  out  1  high in VEND and REFUND

## Operation
- States: IDLE (credit 0), CREDIT (credit > 0), VEND, REFUND.
- Input priority in a single cycle: `cancel` > `select` > `coin_valid`. A coin strobed alongside an accepted `select` or `cancel` is rejected.
- **Coin, IDLE or CREDIT:** compute a 9-bit `{1'b0,sum} + value`.
  - If the result ≤ `MAX_SUM`: `sum` takes the new value and the state becomes CREDIT.
  - Otherwise: `sum` is unchanged and `coin_reject` pulses.
- **Coin, VEND or REFUND:** always rejected (`coin_reject` pulses).
- **`select`, CREDIT, `sum` ≥ `PRICE`:** `sum` ← `sum` − `PRICE`, `candy_sum` ← min(`candy_sum` + 1, 7), state → VEND.
- **`select` otherwise:** ignored; no state change.
  - Covers IDLE, insufficient credit, VEND and REFUND.
- **VEND:** `dispense` stays high while an internal counter runs `VEND_CYCLES` clocks. After the last cycle the state goes to IDLE if `sum` == 0, else CREDIT. `select` and `cancel` are ignored during VEND.
- **`cancel`, CREDIT:** `change` ← `sum`, `change_valid` pulses, `sum` ← 0, state → REFUND. REFUND returns to IDLE on the next clock.
- **`cancel`, IDLE:** ignored; no strobe is issued for a zero refund.
- **`candy_sum`:** cleared only by reset. At 7 it saturates, and vending continues normally.
- **Reset (asserted at any time, including mid-vend or mid-refund):**
  - State → IDLE.
  - `sum`, `candy_sum`, `change`, the vend counter → 0.
  - `dispense`, `change_valid`, `coin_reject`, `busy` → 0.
  - An in-progress `dispense` pulse is truncated immediately.

## Timing
- All outputs are registered.
- Latency from an input strobe to its effect on outputs is 1 clock. A strobe sampled at edge N produces an output change visible after edge N.
- `dispense` rises in the same cycle that `sum` drops by `PRICE`. It is high for exactly `VEND_CYCLES` cycles, then the state exits VEND on the following edge.
- `change_valid` and `coin_reject` are exactly 1 cycle wide. `change` holds its value until the next refund.
- Back-to-back coins on consecutive cycles are each evaluated against the updated `sum`.
- `reset` deassertion is asynchronous to `clk`. The upstream reset synchronizer is outside this block.

## Structure
- Shared package `vend_pkg`:
  - State encoding localparams: IDLE=2'd0, CREDIT=2'd1, VEND=2'd2, REFUND=2'd3.
  - Coin value constants (5, 10, 25, 50).
  - Function `coin_value(coin_type)` returning 8 bits.
- Sub-module `vend_pulse_timer`: loadable down-counter driving `dispense`.
  - Inputs: `clk`, `reset`, `start`, `len` [3:0].
  - Outputs: `active`, `done`.
- The top level holds the FSM, credit arithmetic and output registers.

## Test plan
- **Reset mid-vend:** insert 25+10, select, assert `reset` at dispense cycle 3 → all outputs 0 immediately, IDLE.
- **Exact price:** 25, then select → `sum` 25→0, `candy_sum`=1, `dispense` high 8 cycles, then IDLE with `busy`=0.
- **Accumulate and partial vend:** 50, 10, 5, then select → `sum` 65→40, `candy_sum`=1; a second select → `sum`=15, `candy_sum`=2. A third select is ignored (15 < 25).
- **Overflow reject:** four 50-cent coins (`sum`=200), then a 5 → `coin_reject` pulses once, `sum` stays 200. The same cycle as `select` during VEND is also rejected.
- **Cancel:** 10+25, then cancel → `change`=35 with a 1-cycle `change_valid`, `sum`=0, IDLE after 2 clocks. Cancel while IDLE → no strobe.
- **Priority and saturation:** `cancel`+`select`+coin in one cycle with `sum`=50 → refund 50, no vend, coin rejected. Eight successful vends → `candy_sum` stays 7.
